// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the shared iterative divider (DIV/DIVU).
// Latches operands on request, runs one restoring step per cycle, stalls the
// pipeline while busy and returns {remainder, quotient} for the HI/LO write.
module div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_W-1:0]       rem_q;
  logic [DATA_W-1:0]       quo_q;
  logic [DATA_W-1:0]       dvs_q;
  logic                    neg_quo_q;
  logic                    neg_rem_q;
  logic [2*DATA_W-1:0]     result_q;
  logic                    ready_q;

  logic [DATA_W-1:0]       rem_shift_d;
  logic [DATA_W:0]         trial_d;
  logic [DATA_W-1:0]       rem_d;
  logic [DATA_W-1:0]       quo_d;
  logic                    op1_neg_d;
  logic                    op2_neg_d;

  // Two's-complement negate when requested; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    return neg ? DATA_W'(-sv) : v;
  endfunction

  // One restoring-division step on the current partial remainder/quotient.
  always_comb begin
    rem_shift_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
    trial_d     = {1'b0, rem_shift_d} - {1'b0, dvs_q};
    rem_d       = rem_shift_d;
    quo_d       = {quo_q[DATA_W-2:0], 1'b0};
    if (!trial_d[DATA_W]) begin
      rem_d = trial_d[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end
    op1_neg_d = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg_d = signed_div_i & opdata2_i[DATA_W-1];
  end

  // Divider FSM: operand capture, iteration, result hand-off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_FREE: begin
          ready_q <= 1'b0;
          if (!annul_i && start_i) begin
            if (opdata2_i == '0) begin
              state_q <= ST_BYZERO;
            end else begin
              state_q   <= ST_ON;
              cnt_q     <= '0;
              rem_q     <= '0;
              quo_q     <= fix_sign(opdata1_i, op1_neg_d);
              dvs_q     <= fix_sign(opdata2_i, op2_neg_d);
              neg_quo_q <= op1_neg_d ^ op2_neg_d;
              neg_rem_q <= op1_neg_d;
            end
          end
        end
        ST_BYZERO: begin
          state_q  <= ST_END;
          result_q <= '0;
          ready_q  <= 1'b1;
        end
        ST_ON: begin
          if (annul_i || !start_i) begin
            state_q <= ST_FREE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              state_q  <= ST_END;
              result_q <= {fix_sign(rem_d, neg_rem_q), fix_sign(quo_d, neg_quo_q)};
              ready_q  <= 1'b1;
            end
          end
        end
        ST_END: begin
          if (!start_i) begin
            state_q  <= ST_FREE;
            result_q <= '0;
            ready_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_FREE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed-vector bench for the div_ctrl divider sequencer.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_cmp;
  int n_err;

  div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, measure latency, check result, END hold and release.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input int exp_lat, input logic [63:0] exp_res,
                         input bit disturb);
    int lat;
    bit stall_ok;
    lat = -1;
    stall_ok = 1'b1;
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = sgn;
    start_i = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      #1;
      if (ready_o) begin
        lat = k;
        break;
      end
      if (!stallreq_o) stall_ok = 1'b0;
      if (disturb && k == 5) begin
        opdata1_i = ~a;
        opdata2_i = 32'h0;
        signed_div_i = ~sgn;
      end
      tick();
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall"}, 64'(stall_ok), 64'd1);
    chk({tag, "_res"}, result_o, exp_res);
    tick();
    chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_res"}, result_o, exp_res);
    chk({tag, "_hold_nostall"}, 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    tick();
    chk({tag, "_rel_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_rel_res"}, result_o, 64'd0);
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    tick();
    tick();
    chk("rst_rdy", 64'(ready_o), 64'd0);
    chk("rst_res", result_o, 64'd0);
    chk("rst_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b1;
    tick();

    // Basic unsigned and signed vectors
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b0);
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, {32'd1, 32'hFFFF_FFFD}, 1'b0);
    run_div("divu_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 33, {32'd1, 32'h7FFF_FFFC}, 1'b0);
    run_div("divu_ffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, {32'd0, 32'hFFFF_FFFF}, 1'b0);
    run_div("divu_ffff_fffe", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, {32'd1, 32'd1}, 1'b0);

    // Divide by zero
    run_div("byzero", 32'd1234, 32'd0, 1'b0, 2, 64'd0, 1'b0);

    // Overflow case with operands disturbed mid-operation
    run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33,
            {32'd0, 32'h8000_0000}, 1'b1);

    // Annul in ON at cycle N+10
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    annul_i = 1'b1;
    #1;
    chk("annul_stall", 64'(stallreq_o), 64'd0);
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) seen = 1'b1;
      tick();
    end
    chk("annul_no_rdy", 64'(seen), 64'd0);
    run_div("after_annul", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b0);

    // start_i dropped in ON behaves as annul
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    start_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o) seen = 1'b1;
    end
    chk("drop_no_rdy", 64'(seen), 64'd0);
    run_div("after_drop", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b0);

    // Asynchronous reset at cycle N+20
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_rdy", 64'(ready_o), 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o) seen = 1'b1;
    end
    chk("rst_mid_no_rdy", 64'(seen), 64'd0);

    // Asynchronous reset while holding a non-zero result in END
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("end_rdy", 64'(seen), 64'd1);
    chk("end_res", result_o, {32'd2, 32'd14});
    #2 rst = 1'b0;
    #1;
    chk("rst_end_rdy", 64'(ready_o), 64'd0);
    chk("rst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_div("after_rst", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
